// File: rtl/flop_pkg.sv
// Shared constants and types for the 13-bit flop sample format and the peak tracker.
package flop_pkg;

  localparam int unsigned FLOP_W   = 13;
  localparam int unsigned SIGN_BIT = 12;
  localparam int unsigned MANT_HI  = 11;
  localparam int unsigned MANT_LO  = 4;
  localparam int unsigned EXP_HI   = 3;
  localparam int unsigned EXP_LO   = 0;

  localparam logic POS_SIGN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/flop_greaterthan.sv
// Strict ordering of two flop samples: gt = 1 when a > b.
module flop_greaterthan
  import flop_pkg::*;
(
  input  logic [FLOP_W-1:0] a,
  input  logic [FLOP_W-1:0] b,
  output logic              gt
);

  logic        a_pos;
  logic        b_pos;
  logic [11:0] a_key;
  logic [11:0] b_key;

  // Exponent is the more significant part of the magnitude key.
  assign a_pos = (a[SIGN_BIT] == POS_SIGN);
  assign b_pos = (b[SIGN_BIT] == POS_SIGN);
  assign a_key = {a[EXP_HI:EXP_LO], a[MANT_HI:MANT_LO]};
  assign b_key = {b[EXP_HI:EXP_LO], b[MANT_HI:MANT_LO]};

  always_comb begin
    gt = 1'b0;
    if (a_pos != b_pos) begin
      gt = a_pos;
    end else if (a_pos) begin
      gt = (a_key > b_key);
    end else begin
      gt = (a_key < b_key);
    end
  end

endmodule

// File: rtl/flop_peak_tracker.sv
// Per-frame min/max/argmax/length tracker for flop samples with a valid/ack result port.
module flop_peak_tracker
  import flop_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOP_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [FLOP_W-1:0] peak_max,
  output logic [FLOP_W-1:0] peak_min,
  output logic [IDX_W-1:0]  max_idx,
  output logic [IDX_W:0]    frame_len,
  output logic              overflow,
  output logic              res_valid,
  input  logic              res_ack
);

  localparam logic [IDX_W:0] LEN_FULL = {1'b1, {IDX_W{1'b0}}};

  state_e            state_q, state_d;
  logic [FLOP_W-1:0] peak_max_q, peak_max_d;
  logic [FLOP_W-1:0] peak_min_q, peak_min_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W:0]    frame_len_q, frame_len_d;
  logic              overflow_q, overflow_d;

  logic accept;
  logic new_max;
  logic new_min;

  flop_greaterthan u_gt_max (
    .a  (in_data),
    .b  (peak_max_q),
    .gt (new_max)
  );

  flop_greaterthan u_gt_min (
    .a  (peak_min_q),
    .b  (in_data),
    .gt (new_min)
  );

  assign in_ready  = (state_q != DONE);
  assign res_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    peak_max_d  = peak_max_q;
    peak_min_d  = peak_min_q;
    max_idx_d   = max_idx_q;
    frame_len_d = frame_len_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          peak_max_d  = in_data;
          peak_min_d  = in_data;
          max_idx_d   = '0;
          frame_len_d = {{IDX_W{1'b0}}, 1'b1};
          overflow_d  = 1'b0;
          state_d     = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // A full frame drops further samples but still honours in_last.
          if (frame_len_q == LEN_FULL) begin
            overflow_d = 1'b1;
          end else begin
            if (new_max) begin
              peak_max_d = in_data;
              max_idx_d  = frame_len_q[IDX_W-1:0];
            end
            if (new_min) begin
              peak_min_d = in_data;
            end
            frame_len_d = frame_len_q + 1'b1;
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      peak_max_q  <= '0;
      peak_min_q  <= '0;
      max_idx_q   <= '0;
      frame_len_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      peak_max_q  <= peak_max_d;
      peak_min_q  <= peak_min_d;
      max_idx_q   <= max_idx_d;
      frame_len_q <= frame_len_d;
      overflow_q  <= overflow_d;
    end
  end

  assign peak_max  = peak_max_q;
  assign peak_min  = peak_min_q;
  assign max_idx   = max_idx_q;
  assign frame_len = frame_len_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_flop_peak_tracker.sv
// Directed bench: two trackers (IDX_W = 8 and IDX_W = 2) share one input stream.
module tb_flop_peak_tracker;

  localparam logic [12:0] A = 13'h1105;
  localparam logic [12:0] B = 13'h1806;
  localparam logic [12:0] C = 13'h0806;
  localparam logic [12:0] D = 13'h0105;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        res_ack;

  logic        rdy8, rv8, ovf8;
  logic [12:0] max8, min8;
  logic [7:0]  idx8;
  logic [8:0]  len8;

  logic        rdy2, rv2, ovf2;
  logic [12:0] max2, min2;
  logic [1:0]  idx2;
  logic [2:0]  len2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flop_peak_tracker #(.IDX_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy8), .peak_max(max8), .peak_min(min8),
    .max_idx(idx8), .frame_len(len8), .overflow(ovf8), .res_valid(rv8),
    .res_ack(res_ack)
  );

  flop_peak_tracker #(.IDX_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy2), .peak_max(max2), .peak_min(min2),
    .max_idx(idx2), .frame_len(len2), .overflow(ovf2), .res_valid(rv2),
    .res_ack(res_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [12:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  task automatic check8(input string tag, input logic [12:0] mx, input logic [12:0] mn,
                        input logic [7:0] ix, input logic [8:0] ln, input logic ov);
    check({tag, ".rv"},  32'(rv8),  32'd1);
    check({tag, ".max"}, 32'(max8), 32'(mx));
    check({tag, ".min"}, 32'(min8), 32'(mn));
    check({tag, ".idx"}, 32'(idx8), 32'(ix));
    check({tag, ".len"}, 32'(len8), 32'(ln));
    check({tag, ".ovf"}, 32'(ovf8), 32'(ov));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; res_ack = 1'b0;
    tick(); tick();
    check("rst.rdy8", 32'(rdy8), 32'd1);
    check("rst.rv8",  32'(rv8),  32'd0);
    check("rst.max8", 32'(max8), 32'd0);
    check("rst.min8", 32'(min8), 32'd0);
    check("rst.len8", 32'(len8), 32'd0);
    check("rst.rdy2", 32'(rdy2), 32'd1);
    reset = 1'b0;

    // Frame A,C,B,D back to back
    send(A, 1'b0); send(C, 1'b0); send(B, 1'b0); send(D, 1'b1);
    check8("f1", B, C, 8'd2, 9'd4, 1'b0);
    check("f1.rdy8", 32'(rdy8), 32'd0);
    check("f1.len2", 32'(len2), 32'd4);
    check("f1.ovf2", 32'(ovf2), 32'd0);
    tick();
    check("f1.hold", 32'(max8), 32'(B));
    ack();
    check("f1.ack_rv", 32'(rv8), 32'd0);
    check("f1.ack_rdy", 32'(rdy8), 32'd1);
    check("f1.keep", 32'(max8), 32'(B));

    // Ties, plus in_last without in_valid
    send(A, 1'b0); send(A, 1'b0);
    in_last = 1'b1; tick(); in_last = 1'b0;
    check("f2.lone_last", 32'(rv8), 32'd0);
    send(A, 1'b1);
    check8("f2", A, A, 8'd0, 9'd3, 1'b0);
    ack();

    // Zero signs
    send(13'h0000, 1'b0); send(13'h1000, 1'b1);
    check8("f3", 13'h1000, 13'h0000, 8'd1, 9'd2, 1'b0);
    ack();

    // Single sample, then back-pressure in DONE
    send(D, 1'b1);
    check8("f4", D, D, 8'd0, 9'd1, 1'b0);
    in_data = B; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.rdy", 32'(rdy8), 32'd0);
      check("bp.len", 32'(len8), 32'd1);
    end
    check("bp.max", 32'(max8), 32'(D));
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    check("bp.ack_rv", 32'(rv8), 32'd0);
    check("bp.ack_rdy", 32'(rdy8), 32'd1);
    check("bp.ack_max", 32'(max8), 32'(D));
    tick();
    in_valid = 1'b0;
    check("bp.first_len", 32'(len8), 32'd1);
    check("bp.first_max", 32'(max8), 32'(B));
    check("bp.first_min", 32'(min8), 32'(B));
    send(C, 1'b1);
    check8("f5", B, C, 8'd0, 9'd2, 1'b0);
    ack();

    // Overflow on the narrow tracker; wide tracker sees the whole frame
    send(A, 1'b0); send(A, 1'b0); send(A, 1'b0); send(A, 1'b0);
    send(B, 1'b0); send(C, 1'b1);
    check("ov.rv2",  32'(rv2),  32'd1);
    check("ov.len2", 32'(len2), 32'd4);
    check("ov.ovf2", 32'(ovf2), 32'd1);
    check("ov.max2", 32'(max2), 32'(A));
    check("ov.min2", 32'(min2), 32'(A));
    check("ov.idx2", 32'(idx2), 32'd0);
    check8("ov8", B, C, 8'd4, 9'd6, 1'b0);
    ack();

    // Reset mid-frame
    send(A, 1'b0); send(B, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mr.rdy", 32'(rdy8), 32'd1);
    check("mr.rv",  32'(rv8),  32'd0);
    check("mr.max", 32'(max8), 32'd0);
    check("mr.min", 32'(min8), 32'd0);
    check("mr.idx", 32'(idx8), 32'd0);
    check("mr.len", 32'(len8), 32'd0);
    check("mr.ovf", 32'(ovf8), 32'd0);
    send(D, 1'b1);
    check8("mr.f", D, D, 8'd0, 9'd1, 1'b0);
    check("mr.len2", 32'(len2), 32'd1);
    check("mr.ovf2", 32'(ovf2), 32'd0);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
